drone_call_dispatcher: RTL and testbench

//   Upstream stage of the drone delivery controller. Queues single-cycle

---
 rtl/drone_call_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_drone_call_dispatcher.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/drone_call_dispatcher.sv
// Upstream dispatcher for the drone delivery controller: queues floor-5/floor-6
// requests in a small FIFO, issues one job at a time on Call, and follows each
// job through flight, drop and return-to-base with a per-phase timeout.
module drone_call_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req5,
  input  logic             req6,
  input  logic [1:0]       Floor,
  input  logic [1:0]       Drop,
  input  logic             bird,
  output logic [1:0]       Call,
  output logic             busy,
  output logic [CNT_W-1:0] q_count,
  output logic             overflow,
  output logic             done,
  output logic             abort
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TMR_W-1:0] TmrMax = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  typedef enum logic [2:0] {StIdle, StFly, StDrop, StAbort, StRet} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  mem_q, mem_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dest_q, dest_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        call_q, call_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic              dispatch;
  logic              timed_out;
  logic [1:0]        dest_floor;
  logic [CNT_W-1:0]  free_cnt;
  logic [CNT_W-1:0]  cnt_tmp;
  logic [PtrW-1:0]   wp;

  // Pop the head only when parked at base with no bird emergency.
  assign dispatch   = (state_q == StIdle) && (count_q != '0) && (Floor == 2'b00) && !bird;
  assign timed_out  = (timer_q == TmrMax);
  assign dest_floor = dest_q ? 2'b10 : 2'b01;

  // State and datapath registers; async reset drops Call immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dest_q     <= 1'b0;
      timer_q    <= '0;
      call_q     <= 2'b00;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dest_q     <= dest_d;
      timer_q    <= timer_d;
      call_q     <= call_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic; arrival/drop wins over timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dispatch) state_d = StFly;
      StFly: begin
        if (Floor == dest_floor) state_d = StDrop;
        else if (timed_out)      state_d = StAbort;
      end
      StDrop: begin
        if (Drop[dest_q])   state_d = StRet;
        else if (timed_out) state_d = StAbort;
      end
      StAbort: state_d = StRet;
      StRet:   if (Floor == 2'b00) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FIFO: pop frees a slot before pushes are admitted; req5 is pushed ahead of req6.
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = 1'b0;
    wp         = wr_ptr_q;
    free_cnt   = CntMax - count_q + CNT_W'(dispatch);
    cnt_tmp    = count_q - CNT_W'(dispatch);
    if (dispatch) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (req5) begin
      if (free_cnt != '0) begin
        mem_d[wp] = 1'b0;
        wp        = wp + PtrW'(1);
        free_cnt  = free_cnt - CNT_W'(1);
        cnt_tmp   = cnt_tmp + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (req6) begin
      if (free_cnt != '0) begin
        mem_d[wp] = 1'b1;
        wp        = wp + PtrW'(1);
        cnt_tmp   = cnt_tmp + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
    wr_ptr_d = wp;
    count_d  = cnt_tmp;
  end

  // Job destination and phase timer; timer freezes while a bird is present.
  always_comb begin
    dest_d  = dispatch ? mem_q[rd_ptr_q] : dest_q;
    timer_d = timer_q;
    if (dispatch || (state_q == StFly && state_d == StDrop)) begin
      timer_d = '0;
    end else if ((state_q == StFly || state_q == StDrop) && !bird && !timed_out) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Registered outputs: Call is live only in flight/drop, pulses last one cycle.
  always_comb begin
    call_d  = 2'b00;
    if (state_d == StFly || state_d == StDrop) call_d = dest_d ? 2'b10 : 2'b01;
    done_d  = (state_q == StDrop) && (state_d == StRet);
    abort_d = (state_d == StAbort);
  end

  assign Call     = call_q;
  assign busy     = (state_q != StIdle);
  assign q_count  = count_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_drone_call_dispatcher.sv
// Bench for drone_call_dispatcher: a queue/phase model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_drone_call_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req5 = 1'b0, req6 = 1'b0, bird = 1'b0;
  logic [1:0] Floor = 2'b00, Drop = 2'b00;
  logic [1:0] Call;
  logic       busy, overflow, done, abort;
  logic [2:0] q_count;

  int checks = 0;
  int failures = 0;

  drone_call_dispatcher #(
    .DEPTH(DEPTH), .CNT_W(3), .TIMEOUT(TIMEOUT), .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req5(req5), .req6(req6), .Floor(Floor), .Drop(Drop),
    .bird(bird), .Call(Call), .busy(busy), .q_count(q_count), .overflow(overflow),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  localparam int PhIdle = 0, PhFly = 1, PhDrop = 2, PhAbort = 3, PhRet = 4;
  bit   m_q[$];
  int   m_phase = PhIdle;
  int   m_elapsed = 0;
  bit   m_dest = 1'b0;
  logic [1:0] exp_call = 2'b00;
  logic       exp_busy = 1'b0, exp_ovf = 1'b0, exp_done = 1'b0, exp_abort = 1'b0;
  logic [2:0] exp_count = 3'd0;

  task automatic model_reset();
    m_q.delete();
    m_phase = PhIdle; m_elapsed = 0; m_dest = 1'b0;
    exp_call = 2'b00; exp_busy = 1'b0; exp_ovf = 1'b0; exp_done = 1'b0;
    exp_abort = 1'b0; exp_count = 3'd0;
  endtask

  task automatic model_edge();
    bit pop;
    int free;
    pop = (m_phase == PhIdle) && (m_q.size() > 0) && (Floor == 2'b00) && !bird;
    exp_ovf = 1'b0; exp_done = 1'b0; exp_abort = 1'b0;
    if (pop) m_dest = m_q.pop_front();
    free = DEPTH - m_q.size();
    if (req5) begin
      if (free > 0) begin m_q.push_back(1'b0); free--; end else exp_ovf = 1'b1;
    end
    if (req6) begin
      if (free > 0) begin m_q.push_back(1'b1); free--; end else exp_ovf = 1'b1;
    end
    case (m_phase)
      PhIdle: if (pop) begin m_phase = PhFly; m_elapsed = 0; end
      PhFly: begin
        if (Floor == (m_dest ? 2'd2 : 2'd1)) begin m_phase = PhDrop; m_elapsed = 0; end
        else if (m_elapsed >= TIMEOUT) begin m_phase = PhAbort; exp_abort = 1'b1; end
        else if (!bird) m_elapsed++;
      end
      PhDrop: begin
        if (Drop[m_dest]) begin m_phase = PhRet; exp_done = 1'b1; end
        else if (m_elapsed >= TIMEOUT) begin m_phase = PhAbort; exp_abort = 1'b1; end
        else if (!bird) m_elapsed++;
      end
      PhAbort: m_phase = PhRet;
      default: if (Floor == 2'b00) m_phase = PhIdle;
    endcase
    exp_call  = (m_phase == PhFly || m_phase == PhDrop) ? (m_dest ? 2'b10 : 2'b01) : 2'b00;
    exp_busy  = (m_phase != PhIdle);
    exp_count = 3'(m_q.size());
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_edge();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({Call, busy, q_count, overflow, done, abort} !==
          {exp_call, exp_busy, exp_count, exp_ovf, exp_done, exp_abort}) begin
        failures++;
        $display("FAIL model t=%0t got Call=%b busy=%b cnt=%0d ovf=%b done=%b abort=%b required Call=%b busy=%b cnt=%0d ovf=%b done=%b abort=%b",
                 $time, Call, busy, q_count, overflow, done, abort,
                 exp_call, exp_busy, exp_count, exp_ovf, exp_done, exp_abort);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic wait_call(input logic [1:0] want, input string nm);
    int n;
    n = 0;
    do begin step(1); n++; end while (Call == 2'b00 && n < 20);
    expect_eq(nm, 32'(Call), 32'(want));
  endtask

  // Job already dispatched: arrive, drop, return to base.
  task automatic serve_job(input bit d);
    Floor = d ? 2'b10 : 2'b01;
    step(1);
    Drop = d ? 2'b10 : 2'b01;
    step(1);
    expect_eq("done_pulse", 32'(done), 32'd1);
    expect_eq("call_clear_after_drop", 32'(Call), 32'd0);
    Drop = 2'b00; Floor = 2'b00;
    step(1);
    expect_eq("idle_after_return", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seq[5];
    step(2);
    rst = 1'b0;
    expect_eq("reset_call", 32'(Call), 32'd0);
    expect_eq("reset_count", 32'(q_count), 32'd0);

    // 1: single floor-5 job, latency check
    req5 = 1'b1; step(1); req5 = 1'b0;
    expect_eq("t1_count_after_1", 32'(q_count), 32'd1);
    expect_eq("t1_call_after_1", 32'(Call), 32'd0);
    step(1);
    expect_eq("t1_call_after_2", 32'(Call), 32'd1);
    expect_eq("t1_busy", 32'(busy), 32'd1);
    serve_job(1'b0);

    // 2: both requests in one cycle while busy
    req6 = 1'b1; step(1); req6 = 1'b0; step(1);
    expect_eq("t2_call_fl6", 32'(Call), 32'd2);
    req5 = 1'b1; req6 = 1'b1; step(1); req5 = 1'b0; req6 = 1'b0;
    expect_eq("t2_count_2", 32'(q_count), 32'd2);
    serve_job(1'b1);
    wait_call(2'b01, "t2_second_fl5");
    serve_job(1'b0);
    wait_call(2'b10, "t2_third_fl6");
    serve_job(1'b1);

    // 3: fill, overflow, pop+push at full
    Floor = 2'b11;
    req5 = 1'b1; req6 = 1'b1; step(2); req5 = 1'b0;
    step(1); req6 = 1'b0;
    expect_eq("t3_overflow", 32'(overflow), 32'd1);
    expect_eq("t3_count_full", 32'(q_count), 32'd4);
    step(1);
    expect_eq("t3_overflow_cleared", 32'(overflow), 32'd0);
    Floor = 2'b00; req6 = 1'b1; step(1); req6 = 1'b0;
    expect_eq("t3_popush_no_ovf", 32'(overflow), 32'd0);
    expect_eq("t3_popush_count", 32'(q_count), 32'd4);
    expect_eq("t3_popush_call", 32'(Call), 32'd1);
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_call(seq[i] ? 2'b10 : 2'b01, "t3_drain_order");
      serve_job(seq[i]);
    end

    // 4: timeout, then timeout stretched by bird
    req6 = 1'b1; step(1); req6 = 1'b0; step(1);
    expect_eq("t4_call", 32'(Call), 32'd2);
    step(255);
    expect_eq("t4_no_abort_yet", 32'(abort), 32'd0);
    step(1);
    expect_eq("t4_abort", 32'(abort), 32'd1);
    expect_eq("t4_abort_call", 32'(Call), 32'd0);
    step(2);
    expect_eq("t4_idle", 32'(busy), 32'd0);
    req6 = 1'b1; step(1); req6 = 1'b0; step(1);
    bird = 1'b1; step(10); bird = 1'b0;
    step(255);
    expect_eq("t4b_no_abort_yet", 32'(abort), 32'd0);
    step(1);
    expect_eq("t4b_abort", 32'(abort), 32'd1);
    step(2);

    // 5: reset while in drop phase
    req5 = 1'b1; step(1); req5 = 1'b0; step(1);
    req6 = 1'b1; Floor = 2'b01; step(1); req6 = 1'b0;
    expect_eq("t5_count_queued", 32'(q_count), 32'd1);
    expect_eq("t5_call_held", 32'(Call), 32'd1);
    #2 rst = 1'b1;
    #1;
    expect_eq("t5_call_async", 32'(Call), 32'd0);
    expect_eq("t5_count_async", 32'(q_count), 32'd0);
    expect_eq("t5_busy_async", 32'(busy), 32'd0);
    Floor = 2'b00;
    step(1);
    rst = 1'b0;
    step(3);
    expect_eq("t5_no_done", 32'(done), 32'd0);
    expect_eq("t5_no_abort", 32'(abort), 32'd0);
    expect_eq("t5_still_idle", 32'(busy), 32'd0);

    // 6: bird blocks dispatch
    bird = 1'b1;
    req5 = 1'b1; step(1); req5 = 1'b0;
    step(3);
    expect_eq("t6_blocked_call", 32'(Call), 32'd0);
    expect_eq("t6_blocked_count", 32'(q_count), 32'd1);
    bird = 1'b0;
    step(1);
    expect_eq("t6_call_after_bird", 32'(Call), 32'd1);
    serve_job(1'b0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
